pc_unit_ras: RTL and testbench

- Parametrised next-generation program counter for the core fetch stage.
- Each cycle it selects the next PC from six sources: sequential, conditional branch, jump, call, return, halt.
- Contains a circular return-address stack (RAS) for call/return.
- Supports stall and halt/resume, and reports stack overflow/underflow as sticky error flags.

---
 rtl/pc_unit_ras.sv | 128 ++++++++++++
 tb/tb_pc_unit_ras.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with a circular return-address stack.
// Run/halt control, stall freeze, and sticky RAS overflow/underflow flags.
module pc_unit_ras #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  STEP      = XLEN'(1),
  parameter logic [XLEN-1:0]  RESET_VEC = '0,
  parameter logic [XLEN-1:0]  TRAP_VEC  = XLEN'(16),
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          op_valid,
  input  logic [2:0]                    op,
  input  logic                          br_taken,
  input  logic [XLEN-1:0]               imm,
  input  logic [XLEN-1:0]               jmp_target,
  input  logic                          stall,
  input  logic                          resume,
  output logic [XLEN-1:0]               pc_out,
  output logic [XLEN-1:0]               pc_next,
  output logic [$clog2(RAS_DEPTH):0]    ras_count,
  output logic                          ras_full,
  output logic                          ras_empty,
  output logic                          halted,
  output logic                          err_ovf,
  output logic                          err_udf
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  localparam logic [2:0] OP_BR   = 3'd1;
  localparam logic [2:0] OP_JMP  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

  typedef enum logic {S_RUN, S_HALT} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              push;
  logic [PTR_W-1:0]  top_idx;
  logic [XLEN-1:0]   pc_inc;
  logic [XLEN-1:0]   mem_q [RAS_DEPTH];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wp_d    = wp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    push    = 1'b0;
    top_idx = wp_q - PTR_W'(1);
    pc_inc  = pc_q + STEP;

    if (state_q == S_HALT) begin
      if (resume && !stall) begin
        state_d = S_RUN;
        pc_d    = pc_inc;
      end
    end else if (op_valid && !stall) begin
      case (op)
        OP_BR:   pc_d = br_taken ? (pc_q + imm) : pc_inc;
        OP_JMP:  pc_d = jmp_target;
        OP_CALL: begin
          // A full stack silently drops its oldest entry as the pointer wraps.
          push  = 1'b1;
          pc_d  = jmp_target;
          wp_d  = wp_q + PTR_W'(1);
          if (cnt_q == DEPTH_C) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + CNT_W'(1);
        end
        OP_RET: begin
          if (cnt_q == '0) begin
            pc_d  = TRAP_VEC;
            udf_d = 1'b1;
          end else begin
            pc_d  = mem_q[top_idx];
            wp_d  = top_idx;
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        OP_HALT: state_d = S_HALT;
        default: pc_d = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_VEC;
      wp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Stack storage carries no reset; entries beyond ras_count are never read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= pc_inc;
  end

  assign pc_out    = pc_q;
  assign pc_next   = pc_d;
  assign ras_count = cnt_q;
  assign ras_full  = (cnt_q == DEPTH_C);
  assign ras_empty = (cnt_q == '0);
  assign halted    = (state_q == S_HALT);
  assign err_ovf   = ovf_q;
  assign err_udf   = udf_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Bench for pc_unit_ras: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based model.
module tb_pc_unit_ras;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        br_taken = 1'b0;
  logic [31:0] imm = '0;
  logic [31:0] jmp_target = '0;
  logic        stall = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] pc_out, pc_next;
  logic [2:0]  ras_count;
  logic        ras_full, ras_empty, halted, err_ovf, err_udf;

  pc_unit_ras dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .br_taken(br_taken),
    .imm(imm), .jmp_target(jmp_target), .stall(stall), .resume(resume),
    .pc_out(pc_out), .pc_next(pc_next), .ras_count(ras_count),
    .ras_full(ras_full), .ras_empty(ras_empty), .halted(halted),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: return stack as a plain queue, newest at the back.
  logic [31:0] m_pc = 32'd0;
  logic        m_halt = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
  logic [31:0] m_ras[$];

  function automatic logic [31:0] m_next();
    if (m_halt) return (resume && !stall) ? m_pc + 32'd1 : m_pc;
    if (!op_valid || stall) return m_pc;
    case (op)
      3'd1: return br_taken ? m_pc + imm : m_pc + 32'd1;
      3'd2, 3'd3: return jmp_target;
      3'd4: return (m_ras.size() == 0) ? 32'd16 : m_ras[m_ras.size()-1];
      3'd5: return m_pc;
      default: return m_pc + 32'd1;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc = 32'd0; m_halt = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      m_ras.delete();
    end else begin
      logic [31:0] nxt;
      nxt = m_next();
      if (m_halt) begin
        if (resume && !stall) m_halt = 1'b0;
      end else if (op_valid && !stall) begin
        if (op == 3'd3) begin
          m_ras.push_back(m_pc + 32'd1);
          if (m_ras.size() > 4) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
        end else if (op == 3'd4) begin
          if (m_ras.size() == 0) m_udf = 1'b1;
          else void'(m_ras.pop_back());
        end else if (op == 3'd5) begin
          m_halt = 1'b1;
        end
      end
      m_pc = nxt;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("pc_out",    pc_out,          m_pc);
      chk("pc_next",   pc_next,         m_next());
      chk("ras_count", 32'(ras_count),  32'(m_ras.size()));
      chk("ras_full",  32'(ras_full),   32'(m_ras.size() == 4));
      chk("ras_empty", 32'(ras_empty),  32'(m_ras.size() == 0));
      chk("halted",    32'(halted),     32'(m_halt));
      chk("err_ovf",   32'(err_ovf),    32'(m_ovf));
      chk("err_udf",   32'(err_udf),    32'(m_udf));
    end
  end

  task automatic apply(input logic v, input logic [2:0] o, input logic bt,
                       input logic [31:0] im, input logic [31:0] tg,
                       input logic st, input logic rs);
    @(posedge clk);
    #1;
    op_valid = v; op = o; br_taken = bt; imm = im; jmp_target = tg;
    stall = st; resume = rs;
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] tg);
    apply(1'b1, o, 1'b0, 32'd0, tg, 1'b0, 1'b0);
  endtask

  initial begin
    #3;
    chk("rst pc",    pc_out, 32'd0);
    chk("rst count", 32'(ras_count), 32'd0);
    chk("rst flags", {29'd0, halted, err_ovf, err_udf}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Sequential stepping and hold without op_valid
    run_op(3'd0, 0); chk("seq0", pc_out, 32'd0);
    run_op(3'd0, 0); chk("seq1", pc_out, 32'd1);
    run_op(3'd0, 0); chk("seq2", pc_out, 32'd2);
    idle();          chk("seq3", pc_out, 32'd3);
    idle();          chk("hold", pc_out, 32'd3);
    #1 rst = 1'b0;
    #1 chk("async rst", pc_out, 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Branches and wrap-around
    run_op(3'd2, 32'd8);
    apply(1'b1, 3'd1, 1'b1, 32'hFFFF_FFFD, 0, 1'b0, 1'b0); chk("br at 8", pc_out, 32'd8);
    apply(1'b1, 3'd1, 1'b0, 32'hFFFF_FFFD, 0, 1'b0, 1'b0); chk("br taken", pc_out, 32'd5);
    run_op(3'd2, 32'hFFFF_FFFF); chk("br not taken", pc_out, 32'd6);
    run_op(3'd0, 0); chk("at max", pc_out, 32'hFFFF_FFFF);
    idle();          chk("wrap", pc_out, 32'd0);

    // Nested call/return
    run_op(3'd2, 32'd10);
    run_op(3'd3, 32'd100); chk("c0 pc", pc_out, 32'd10);
    run_op(3'd3, 32'd200); chk("c1 pc", pc_out, 32'd100); chk("c1 cnt", 32'(ras_count), 32'd1);
    run_op(3'd4, 0);       chk("c2 pc", pc_out, 32'd200); chk("c2 cnt", 32'(ras_count), 32'd2);
    run_op(3'd4, 0);       chk("r1 pc", pc_out, 32'd101); chk("r1 cnt", 32'(ras_count), 32'd1);
    idle();                chk("r2 pc", pc_out, 32'd11);  chk("r2 empty", 32'(ras_empty), 32'd1);

    // Overflow then underflow: pushes 12,41,51,61,71, oldest (12) lost
    run_op(3'd3, 32'd40);
    run_op(3'd3, 32'd50); chk("o1", pc_out, 32'd40);
    run_op(3'd3, 32'd60); chk("o2", pc_out, 32'd50);
    run_op(3'd3, 32'd70); chk("o3", pc_out, 32'd60);
    run_op(3'd3, 32'd80); chk("o4", pc_out, 32'd70); chk("o4 ovf", 32'(err_ovf), 32'd0);
    run_op(3'd4, 0); chk("o5", pc_out, 32'd80); chk("ovf", 32'(err_ovf), 32'd1);
    chk("full cnt", 32'(ras_count), 32'd4); chk("full", 32'(ras_full), 32'd1);
    run_op(3'd4, 0); chk("ret71", pc_out, 32'd71);
    run_op(3'd4, 0); chk("ret61", pc_out, 32'd61);
    run_op(3'd4, 0); chk("ret51", pc_out, 32'd51);
    run_op(3'd4, 0); chk("ret41", pc_out, 32'd41); chk("udf pre", 32'(err_udf), 32'd0);
    idle(); chk("trap", pc_out, 32'd16); chk("udf", 32'(err_udf), 32'd1);
    chk("udf cnt", 32'(ras_count), 32'd0);

    // Stalled call freezes everything, then executes exactly once
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 3'd3, 1'b0, 0, 32'd300, 1'b1, 1'b0);
      chk("stall pc", pc_out, 32'd16); chk("stall next", pc_next, 32'd16);
      chk("stall cnt", 32'(ras_count), 32'd0);
    end
    run_op(3'd3, 32'd300); chk("unstall pc", pc_out, 32'd16);
    idle(); chk("call pc", pc_out, 32'd300); chk("call cnt", 32'(ras_count), 32'd1);

    // Halt, ignored ops, stalled resume, resume
    run_op(3'd2, 32'd20);
    run_op(3'd5, 0); chk("halt pc", pc_out, 32'd20);
    for (int i = 0; i < 5; i++) begin
      run_op(3'd0, 0); chk("halted", 32'(halted), 32'd1); chk("halted pc", pc_out, 32'd20);
    end
    apply(1'b0, 3'd0, 1'b0, 0, 0, 1'b1, 1'b1); chk("res stall", pc_out, 32'd20);
    apply(1'b0, 3'd0, 1'b0, 0, 0, 1'b1, 1'b1); chk("res stall2", pc_out, 32'd20);
    apply(1'b0, 3'd0, 1'b0, 0, 0, 1'b0, 1'b1); chk("res next", pc_next, 32'd21);
    idle(); chk("resumed pc", pc_out, 32'd21); chk("resumed", 32'(halted), 32'd0);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      if (o == 3'd5 && $urandom_range(0, 3) != 0) o = 3'd3;
      apply($urandom_range(0, 3) != 0, o, 1'($urandom),
            32'($urandom_range(0, 64)) - 32'd32, $urandom,
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
      end
    end
    idle(); idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
